// File: rtl/hex_rotate_pkg.sv
// Shared types, character codes and rotation helpers for the hex rotation sequencer.
package hex_rotate_pkg;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  typedef logic [1:0] pos_t;

  localparam logic [1:0] CODE_D     = 2'b00;
  localparam logic [1:0] CODE_E     = 2'b01;
  localparam logic [1:0] CODE_ONE   = 2'b10;
  localparam logic [1:0] CODE_BLANK = 2'b11;

  // Positions live in 0..2; dir=1 steps backwards (equivalent to +2 mod 3).
  function automatic pos_t adv_pos(input pos_t p, input logic dir);
    if (!dir) adv_pos = (p == 2'd2) ? 2'd0 : p + 2'd1;
    else      adv_pos = (p == 2'd0) ? 2'd2 : p - 2'd1;
  endfunction

  // Character list L = [c2, c1, c0] with c2 in the top bits of the message.
  function automatic logic [1:0] pick_char(input logic [5:0] m, input pos_t idx);
    case (idx)
      2'd0:    pick_char = m[5:4];
      2'd1:    pick_char = m[3:2];
      default: pick_char = m[1:0];
    endcase
  endfunction

endpackage

// File: rtl/hex_rotate_prescaler.sv
// Modulo-TICKS_PER_STEP counter with clear and enable; o_tick marks the last count while enabled.
module hex_rotate_prescaler #(
  parameter int TICKS_PER_STEP = 50_000_000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int CW = (TICKS_PER_STEP > 2) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_STEP - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr)  r_cnt <= '0;
    else if (i_en)       r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
  end

  assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/hex_rotate_ctrl.sv
// Rotating 3-character message sequencer for HEX2..HEX0 (auto on prescaled tick, manual step in HOLD).
// Optional HOLD blinking is enabled with the HEX_ROTATE_BLINK_EN macro.
module hex_rotate_ctrl
  import hex_rotate_pkg::*;
#(
  parameter int TICKS_PER_STEP = 50_000_000
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic       load,
  input  logic [5:0] msg,
  input  logic       run,
  input  logic       step,
  input  logic       dir,
  output logic [1:0] hex2_code,
  output logic [1:0] hex1_code,
  output logic [1:0] hex0_code,
  output logic [1:0] rot_pos,
  output logic       tick
);

  state_t     r_state, w_state_next;
  pos_t       r_pos, w_pos_next;
  logic [5:0] r_msg, w_msg_next;
  logic       r_phase, w_phase_next;
  logic [1:0] r_hex2, r_hex1, r_hex0;
  logic       w_tick, w_pre_en, w_pre_clr, w_blank;

`ifdef HEX_ROTATE_BLINK_EN
  assign w_pre_en = (r_state == RUN) || (r_state == HOLD);
`else
  assign w_pre_en = (r_state == RUN);
`endif
  // Any state change or load restarts the step interval from zero.
  assign w_pre_clr = load || (w_state_next != r_state);

  hex_rotate_prescaler #(
    .TICKS_PER_STEP(TICKS_PER_STEP)
  ) u_prescaler (
    .i_clk  (CLOCK_50),
    .i_rst  (Reset),
    .i_clr  (w_pre_clr),
    .i_en   (w_pre_en),
    .o_tick (w_tick)
  );

  always_comb begin
    w_state_next = r_state;
    w_pos_next   = r_pos;
    w_msg_next   = r_msg;
    w_phase_next = r_phase;
    if (load) begin
      w_msg_next   = msg;
      w_pos_next   = 2'd0;
      w_phase_next = 1'b0;
      w_state_next = run ? RUN : HOLD;
    end else begin
      case (r_state)
        RUN: begin
          if (!run) begin
            w_state_next = HOLD;
            w_phase_next = 1'b0;
          end else if (w_tick) begin
            w_pos_next = adv_pos(r_pos, dir);
          end
        end
        HOLD: begin
          if (run) begin
            w_state_next = RUN;
            w_phase_next = 1'b0;
          end else if (step) begin
            w_pos_next   = adv_pos(r_pos, dir);
            w_phase_next = 1'b0;
          end
`ifdef HEX_ROTATE_BLINK_EN
          else if (w_tick) begin
            w_phase_next = ~r_phase;
          end
`endif
        end
        default: ;
      endcase
    end
    w_blank = (w_state_next == IDLE) || w_phase_next;
  end

  always_ff @(posedge CLOCK_50) begin
    if (Reset) begin
      r_state <= IDLE;
      r_pos   <= 2'd0;
      r_msg   <= {3{CODE_BLANK}};
      r_phase <= 1'b0;
      r_hex2  <= CODE_BLANK;
      r_hex1  <= CODE_BLANK;
      r_hex0  <= CODE_BLANK;
    end else begin
      r_state <= w_state_next;
      r_pos   <= w_pos_next;
      r_msg   <= w_msg_next;
      r_phase <= w_phase_next;
      r_hex2  <= w_blank ? CODE_BLANK : pick_char(w_msg_next, w_pos_next);
      r_hex1  <= w_blank ? CODE_BLANK : pick_char(w_msg_next, adv_pos(w_pos_next, 1'b0));
      r_hex0  <= w_blank ? CODE_BLANK : pick_char(w_msg_next, adv_pos(w_pos_next, 1'b1));
    end
  end

  assign hex2_code = r_hex2;
  assign hex1_code = r_hex1;
  assign hex0_code = r_hex0;
  assign rot_pos   = r_pos;
  assign tick      = w_tick;

endmodule

// File: tb/tb_hex_rotate_ctrl.sv
// Self-checking bench for hex_rotate_ctrl: behavioural model plus directed and random stimulus.
module tb_hex_rotate_ctrl;

  localparam int T = 4;
`ifdef HEX_ROTATE_BLINK_EN
  localparam bit BLINK = 1'b1;
`else
  localparam bit BLINK = 1'b0;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       Reset = 1'b1;
  logic       load = 1'b0;
  logic [5:0] msg = 6'd0;
  logic       run = 1'b0;
  logic       step = 1'b0;
  logic       dir = 1'b0;
  logic [1:0] hex2_code, hex1_code, hex0_code, rot_pos;
  logic       tick;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  hex_rotate_ctrl #(.TICKS_PER_STEP(T)) dut (
    .CLOCK_50 (CLOCK_50),
    .Reset    (Reset),
    .load     (load),
    .msg      (msg),
    .run      (run),
    .step     (step),
    .dir      (dir),
    .hex2_code(hex2_code),
    .hex1_code(hex1_code),
    .hex0_code(hex0_code),
    .rot_pos  (rot_pos),
    .tick     (tick)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Model: mode 0=idle 1=run 2=hold; message list L[0..2] = c2,c1,c0.
  int m_st = 0;
  int m_p = 0;
  int m_cnt = 0;
  int m_ph = 0;
  int m_L[3] = '{3, 3, 3};

  function automatic int nxt(int p, bit d);
    return d ? (p + 2) % 3 : (p + 1) % 3;
  endfunction

  function automatic int m_code(int k);
    if (m_st == 0 || m_ph != 0) return 3;
    return m_L[(m_p + k) % 3];
  endfunction

  function automatic int m_tick();
    return ((m_st == 1 || (BLINK && m_st == 2)) && m_cnt == T - 1) ? 1 : 0;
  endfunction

  always @(posedge CLOCK_50) begin
    int tk;
    tk = m_tick();
    if (Reset) begin
      m_st = 0; m_p = 0; m_cnt = 0; m_ph = 0; m_L = '{3, 3, 3};
    end else if (load) begin
      m_L[0] = int'(msg[5:4]); m_L[1] = int'(msg[3:2]); m_L[2] = int'(msg[1:0]);
      m_p = 0; m_cnt = 0; m_ph = 0; m_st = run ? 1 : 2;
    end else if (m_st == 1) begin
      if (!run) begin
        m_st = 2; m_cnt = 0; m_ph = 0;
      end else begin
        if (tk != 0) m_p = nxt(m_p, dir);
        m_cnt = (m_cnt + 1) % T;
      end
    end else if (m_st == 2) begin
      if (run) begin
        m_st = 1; m_cnt = 0; m_ph = 0;
      end else begin
        if (step) begin
          m_p = nxt(m_p, dir); m_ph = 0;
        end else if (tk != 0) begin
          m_ph = 1 - m_ph;
        end
        if (BLINK) m_cnt = (m_cnt + 1) % T;
      end
    end
  end

  task automatic cmp(input string nm, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", nm, got, exp, $time);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (chk_en) begin
      cmp("model_hex2", int'(hex2_code), m_code(0));
      cmp("model_hex1", int'(hex1_code), m_code(1));
      cmp("model_hex0", int'(hex0_code), m_code(2));
      cmp("model_rot_pos", int'(rot_pos), m_p);
      cmp("model_tick", int'(tick), m_tick());
    end
  end

  task automatic cyc();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic lit_codes(input string nm, input int h2, input int h1, input int h0, input int p);
    cmp({nm, "_hex2"}, int'(hex2_code), h2);
    cmp({nm, "_hex1"}, int'(hex1_code), h1);
    cmp({nm, "_hex0"}, int'(hex0_code), h0);
    cmp({nm, "_rot"}, int'(rot_pos), p);
  endtask

  initial begin
    cyc();
    chk_en = 1'b1;
    cyc();
    Reset = 1'b0;
    repeat (10) cyc();
    lit_codes("idle", 3, 3, 3, 0);

    // Forward rotation of d,E,1
    msg = 6'b000110; run = 1'b1; dir = 1'b0; load = 1'b1;
    cyc(); load = 1'b0;
    lit_codes("fwd_load", 0, 1, 2, 0);
    repeat (T) cyc();
    lit_codes("fwd_1", 1, 2, 0, 1);
    repeat (T) cyc();
    lit_codes("fwd_2", 2, 0, 1, 2);
    repeat (T) cyc();
    lit_codes("fwd_wrap", 0, 1, 2, 0);

    // Reverse rotation
    dir = 1'b1; load = 1'b1;
    cyc(); load = 1'b0;
    lit_codes("rev_load", 0, 1, 2, 0);
    repeat (T) cyc();
    lit_codes("rev_1", 2, 0, 1, 2);
    repeat (T) cyc();
    lit_codes("rev_2", 1, 2, 0, 1);

    // Manual stepping in HOLD, then step ignored in RUN
    run = 1'b0;
    cyc();
    dir = 1'b0; step = 1'b1;
    cyc(); step = 1'b0;
    lit_codes("step_1", 2, 0, 1, 2);
    step = 1'b1;
    cyc(); step = 1'b0;
    lit_codes("step_2", 0, 1, 2, 0);
    repeat (2) cyc();
    cmp("hold_frozen_rot", int'(rot_pos), 0);
    run = 1'b1;
    cyc();
    step = 1'b1;
    cyc(); step = 1'b0;
    cmp("step_in_run_rot", int'(rot_pos), 0);

    // Load coinciding with tick at p=2
    load = 1'b1; msg = 6'b000110;
    cyc(); load = 1'b0;
    repeat (2 * T) cyc();
    cmp("pre_load_rot", int'(rot_pos), 2);
    repeat (T - 1) cyc();
    cmp("pre_load_tick", int'(tick), 1);
    msg = 6'b011011; load = 1'b1;
    cyc(); load = 1'b0;
    lit_codes("load_on_tick", 1, 2, 3, 0);
    repeat (2) cyc();
    Reset = 1'b1;
    cyc(); Reset = 1'b0;
    lit_codes("reset_mid_run", 3, 3, 3, 0);
    cmp("reset_tick", int'(tick), 0);

    // HOLD display: steady, or blinking when the option is built in
    msg = 6'b000110; run = 1'b0; load = 1'b1;
    cyc(); load = 1'b0;
    lit_codes("hold_load", 0, 1, 2, 0);
    repeat (T - 1) cyc();
    cmp("hold_tick", int'(tick), BLINK ? 1 : 0);
    cyc();
    if (BLINK) lit_codes("hold_blank", 3, 3, 3, 0);
    else       lit_codes("hold_steady", 0, 1, 2, 0);
    repeat (T) cyc();
    lit_codes("hold_show", 0, 1, 2, 0);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      Reset = ($urandom_range(0, 299) == 0);
      load  = ($urandom_range(0, 19) == 0);
      msg   = 6'($urandom);
      if ($urandom_range(0, 29) == 0) run = ~run;
      step  = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 39) == 0) dir = ~dir;
      cyc();
    end
    Reset = 1'b0; load = 1'b0; step = 1'b0;
    repeat (3) cyc();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hex_rotate_ctrl.md
# hex_rotate_ctrl

Sequencer for the three-digit 2-bit character path (codes: d=00, E=01, 1=10, blank=11) feeding the existing per-digit character decoders on HEX2..HEX0. Replaces the manual switch-driven rotation select: holds a loaded 3-character message, advances the rotation position automatically on a prescaled tick or manually on a step pulse, and drives one 2-bit code per display. Sits between board inputs (SW/KEY after synchronisation) and the three character decoders.

## Interface
- TICKS_PER_STEP, 50_000_000, CLOCK_50 cycles per rotation step in RUN (≥2); 1 Hz at 50 MHz.
- CLOCK_50  in  1  system clock, all logic on its rising edge.
- Reset  in  1  synchronous, active-high; one clock, single domain.
- load  in  1  single-cycle pulse; captures msg.
- msg  in  6  {c2,c1,c0}: c2=msg[5:4], c1=msg[3:2], c0=msg[1:0].
- run  in  1  level; 1 = auto-rotate, 0 = hold.
- step  in  1  single-cycle pulse; manual advance, HOLD only.
- dir  in  1  0 = position increments, 1 = decrements.
- hex2_code, hex1_code, hex0_code  out  2 each  registered codes to the decoders.
- rot_pos  out  2  current rotation position, 0..2 (3 never produced).
- tick  out  1  one-cycle pulse when prescaler wraps.

## Operation
- States: IDLE, RUN, HOLD.
- IDLE: all codes 11, rot_pos 0, prescaler 0. Only load leaves IDLE: go to RUN if run=1, else HOLD.
- RUN: prescaler counts 0..TICKS_PER_STEP-1, wraps to 0 asserting tick; each tick advances rot_pos. run=0 → HOLD.
- HOLD: rot_pos frozen; step advances once. run=1 → RUN with prescaler cleared to 0.
- Advance: dir=0 → (p+1) mod 3; dir=1 → (p+2) mod 3. Wrap 2→0 / 0→2 is mandatory; no value 3.
- Mapping with L=[c2,c1,c0]: hex2_code=L[p], hex1_code=L[(p+1) mod 3], hex0_code=L[(p+2) mod 3]. p=0 shows c2,c1,c0; p=1 shows c1,c0,c2.
- load (any non-IDLE state): capture msg, p←0, prescaler←0; state follows run. Message register stays unchanged until next load.
- Priority in one cycle: Reset > load > run change > tick/step.
- step in RUN or IDLE: ignored. step and tick cannot coincide (step HOLD-only, tick advances RUN-only).
- Reset mid-operation: IDLE next edge, message cleared to 111111, all outputs at reset values.

## Timing
- Reset values: hex*_code=11, rot_pos=0, tick=0, state IDLE.
- load at edge N → codes reflect new msg, p=0 after edge N+1 (one-cycle latency).
- tick high for the cycle in which prescaler = TICKS_PER_STEP-1. rot_pos and codes update on the same edge that returns prescaler to 0.
- Entering RUN: first advance exactly TICKS_PER_STEP cycles later.
- step at edge N → new codes after edge N+1.

## Configuration
- HEX_ROTATE_BLINK_EN defined: in HOLD the prescaler free-runs and a blink phase toggles on each tick; phase=1 forces all three codes to 11, phase=0 shows normal mapping. Phase cleared on leaving HOLD, on load and on step (step shows digits immediately). tick pulses in HOLD.
- Undefined: HOLD displays steadily, prescaler held at 0, tick never asserts in HOLD.

## Structure
- Package hex_rotate_pkg: state enum (IDLE, RUN, HOLD), code constants CODE_D=2'b00, CODE_E=2'b01, CODE_ONE=2'b10, CODE_BLANK=2'b11, position type 2-bit.
- One sub-module: hex_rotate_prescaler (parameterised counter, clear input, enable input, tick output). Next-position and mapping logic stay in the top.

## Test plan (TICKS_PER_STEP=4)
- Reset then idle 10 cycles → codes 11/11/11, rot_pos 0, tick never high.
- load msg=000110 (d,E,1), run=1, dir=0 → after 1 cycle d/E/1; every 4 cycles E/1/d, 1/d/E, d/E/1; rot_pos 0,1,2,0.
- Same with dir=1 → d/E/1 then 1/d/E then E/1/d; rot_pos 0,2,1.
- run=0, step ×2 → one advance per pulse, 1-cycle latency; step during RUN → no change in rot_pos.
- load at same cycle as tick with p=2 → rot_pos 0 and new msg, no advance; Reset asserted mid-RUN → next cycle 11/11/11, rot_pos 0, IDLE.
- With HEX_ROTATE_BLINK_EN, HOLD on d/E/1 → alternates d/E/1 and 11/11/11 every 4 cycles; without macro → steady d/E/1, no tick.
